// File: rtl/hram_test_pkg.sv
// Shared state encoding, widths and data-pattern helper for the
// HyperRAM test sequencer.
package hram_test_pkg;

  localparam logic [31:0] SEED_DEF = 32'hA5C3_5A3C;
  localparam int ERR_W = 16;
  localparam int CNT_W = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_RD_REQ,
    S_RD_WAIT,
    S_DONE
  } state_t;

  function automatic logic [31:0] pattern(
    input logic [15:0] i,
    input logic [31:0] seed
  );
    return {~i, i} ^ seed;
  endfunction

endpackage

// File: rtl/hram_pattern_gen.sv
// Registered address/data generator; the held data doubles as the
// expected value when checking read-back words.
module hram_pattern_gen
  import hram_test_pkg::*;
#(
  parameter int unsigned ADDR_W    = 21,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [31:0] SEED      = SEED_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [31:0]       idx,
  input  logic              flip,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       data
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= '0;
      data <= '0;
    end else if (load) begin
      addr <= ADDR_W'(BASE_ADDR + idx);
      data <= pattern(idx[15:0], SEED) ^ {31'b0, flip};
    end
  end

endmodule

// File: rtl/hram_test_sequencer.sv
// HyperRAM write/read-back pattern tester. Build with HRAM_TEST_ERRINJ_EN
// to corrupt bit 0 of word 5 on every odd-numbered pass.
module hram_test_sequencer
  import hram_test_pkg::*;
#(
  parameter int unsigned ADDR_W      = 21,
  parameter int unsigned NUM_WORDS   = 256,
  parameter int unsigned BASE_ADDR   = 0,
  parameter logic [31:0] SEED        = SEED_DEF,
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter bit          LOOP        = 1'b1
) (
  input  logic              memoryClock,
  input  logic              resetn,
  input  logic              start,
  output logic              ctrlReq,
  output logic              ctrlWrite,
  output logic [ADDR_W-1:0] ctrlAddr,
  output logic [31:0]       ctrlWriteData,
  input  logic              ctrlAck,
  input  logic              ctrlReadValid,
  input  logic [31:0]       ctrlReadData,
  output logic [31:0]       readReg,
  output logic              readDataValid,
  output logic [CNT_W-1:0]  testStateCounter,
  output logic              testDone,
  output logic              testPass,
  output logic [ERR_W-1:0]  errorCount,
  output logic              timeoutErr
);

  localparam int TW =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [31:0] LAST = 32'(NUM_WORDS - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);

  state_t state, state_n;

  logic [31:0]      idx, idx_n;
  logic [TW-1:0]    tmo, tmo_n;
  logic             req_n, wr_n;
  logic [31:0]      rd_n;
  logic             rdv_n;
  logic [CNT_W-1:0] cnt_n, cnt_up;
  logic             done_n, pass_n;
  logic [ERR_W-1:0] err_n, err_up;
  logic             terr_n;
  logic             load, flip;
  logic             last, tmo_hit;
  logic             busy, progress, accept;

  assign last    = (idx == LAST);
  assign tmo_hit = (tmo == TLIM);
  assign cnt_up  = testStateCounter + 1'b1;
  assign err_up  = (errorCount == '1) ?
                   errorCount : errorCount + 1'b1;

  assign busy = (state == S_WR_REQ) ||
                (state == S_RD_REQ) ||
                (state == S_RD_WAIT);
  assign progress = (state == S_RD_WAIT) ?
                    ctrlReadValid : ctrlAck;
  assign accept = ctrlReadValid &&
                  ((state == S_RD_WAIT) ||
                   ((state == S_RD_REQ) && ctrlAck));

`ifdef HRAM_TEST_ERRINJ_EN
  assign flip = wr_n && testStateCounter[0] &&
                (idx_n == 32'd5);
`else
  assign flip = 1'b0;
`endif

  hram_pattern_gen #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .SEED      (SEED)
  ) u_gen (
    .clk   (memoryClock),
    .rst_n (resetn),
    .load  (load),
    .idx   (idx_n),
    .flip  (flip),
    .addr  (ctrlAddr),
    .data  (ctrlWriteData)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    tmo_n   = tmo;
    req_n   = ctrlReq;
    wr_n    = ctrlWrite;
    rd_n    = readReg;
    rdv_n   = 1'b0;
    cnt_n   = testStateCounter;
    done_n  = testDone;
    pass_n  = testPass;
    err_n   = errorCount;
    terr_n  = timeoutErr;
    load    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_WR_REQ;
          idx_n   = '0;
          err_n   = '0;
          terr_n  = 1'b0;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          req_n   = 1'b1;
          wr_n    = 1'b1;
          load    = 1'b1;
          tmo_n   = '0;
        end
      end
      S_WR_REQ: begin
        if (ctrlAck) begin
          tmo_n = '0;
          load  = 1'b1;
          if (last) begin
            state_n = S_RD_REQ;
            idx_n   = '0;
            wr_n    = 1'b0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      S_RD_REQ: begin
        if (ctrlAck && !ctrlReadValid) begin
          state_n = S_RD_WAIT;
          req_n   = 1'b0;
          tmo_n   = '0;
        end
      end
      S_RD_WAIT: begin
      end
      S_DONE: begin
        if (!start || (LOOP && testPass))
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // read capture and the handshake watchdog are shared by all busy states
    if (accept) begin
      rd_n  = ctrlReadData;
      rdv_n = 1'b1;
      if (ctrlReadData != ctrlWriteData)
        err_n = err_up;
      if (last) begin
        state_n = S_DONE;
        req_n   = 1'b0;
        done_n  = 1'b1;
        pass_n  = (err_n == '0) && !timeoutErr;
        cnt_n   = cnt_up;
      end else begin
        state_n = S_RD_REQ;
        idx_n   = idx + 1'b1;
        req_n   = 1'b1;
        load    = 1'b1;
        tmo_n   = '0;
      end
    end else if (busy && !progress) begin
      if (tmo_hit) begin
        state_n = S_DONE;
        req_n   = 1'b0;
        terr_n  = 1'b1;
        done_n  = 1'b1;
        pass_n  = 1'b0;
        cnt_n   = cnt_up;
      end else begin
        tmo_n = tmo + 1'b1;
      end
    end
  end

  always_ff @(posedge memoryClock) begin
    if (!resetn) begin
      state            <= S_IDLE;
      idx              <= '0;
      tmo              <= '0;
      ctrlReq          <= 1'b0;
      ctrlWrite        <= 1'b0;
      readReg          <= '0;
      readDataValid    <= 1'b0;
      testStateCounter <= '0;
      testDone         <= 1'b0;
      testPass         <= 1'b0;
      errorCount       <= '0;
      timeoutErr       <= 1'b0;
    end else begin
      state            <= state_n;
      idx              <= idx_n;
      tmo              <= tmo_n;
      ctrlReq          <= req_n;
      ctrlWrite        <= wr_n;
      readReg          <= rd_n;
      readDataValid    <= rdv_n;
      testStateCounter <= cnt_n;
      testDone         <= done_n;
      testPass         <= pass_n;
      errorCount       <= err_n;
      timeoutErr       <= terr_n;
    end
  end

endmodule

// File: tb/tb_hram_test_sequencer.sv
// Scoreboard bench for hram_test_sequencer with a small HyperRAM
// controller model (ack after 2 cycles, read data 4 cycles later).
module tb_hram_test_sequencer;

  localparam int NW = 8;
  localparam logic [31:0] SEEDV = 32'hA5C3_5A3C;
`ifdef HRAM_TEST_ERRINJ_EN
  localparam bit ERRINJ = 1'b1;
`else
  localparam bit ERRINJ = 1'b0;
`endif

  logic        memoryClock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        ctrlReq, ctrlWrite;
  logic [20:0] ctrlAddr;
  logic [31:0] ctrlWriteData;
  logic        ctrlAck = 1'b0;
  logic        ctrlReadValid = 1'b0;
  logic [31:0] ctrlReadData = '0;
  logic [31:0] readReg;
  logic        readDataValid;
  logic [6:0]  testStateCounter;
  logic        testDone, testPass;
  logic [15:0] errorCount;
  logic        timeoutErr;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb [$];
  logic [31:0] mem [0:NW-1];
  int woff = 0, roff = 0, pend_off = 0;
  int rd_cnt = 0, age = 0, rdv_cnt = 0;
  int corrupt_off = -1;
  bit mute = 0, fast = 0, stray = 0, inj_run = 0;
  bit first_seen = 0;
  logic [31:0] first_rd = '0;

  always #5 memoryClock = ~memoryClock;

  hram_test_sequencer #(
    .ADDR_W      (21),
    .NUM_WORDS   (NW),
    .BASE_ADDR   (0),
    .SEED        (SEEDV),
    .TIMEOUT_CYC (15),
    .LOOP        (1'b1)
  ) dut (
    .memoryClock      (memoryClock),
    .resetn           (resetn),
    .start            (start),
    .ctrlReq          (ctrlReq),
    .ctrlWrite        (ctrlWrite),
    .ctrlAddr         (ctrlAddr),
    .ctrlWriteData    (ctrlWriteData),
    .ctrlAck          (ctrlAck),
    .ctrlReadValid    (ctrlReadValid),
    .ctrlReadData     (ctrlReadData),
    .readReg          (readReg),
    .readDataValid    (readDataValid),
    .testStateCounter (testStateCounter),
    .testDone         (testDone),
    .testPass         (testPass),
    .errorCount       (errorCount),
    .timeoutErr       (timeoutErr)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [31:0] tb_pat(input int off);
    logic [15:0] i;
    i = off[15:0];
    return {~i, i} ^ SEEDV;
  endfunction

  function automatic logic [31:0] flip_bit(input int off);
    return {31'b0, ERRINJ && inj_run && (off == 5)};
  endfunction

  task automatic issue_read(input int off);
    logic [31:0] cb;
    cb = (off == corrupt_off) ? 32'h1 : 32'h0;
    ctrlReadValid = 1'b1;
    ctrlReadData  = mem[off] ^ cb;
    sb.push_back(tb_pat(off) ^ flip_bit(off) ^ cb);
  endtask

  // controller model
  initial forever begin
    @(posedge memoryClock);
    #1;
    ctrlAck = 1'b0;
    ctrlReadValid = 1'b0;
    if (!resetn) begin
      age = 0;
      rd_cnt = 0;
    end else if (stray) begin
      ctrlAck = 1'b1;
      ctrlReadValid = 1'b1;
      ctrlReadData = 32'hDEAD_BEEF;
      stray = 0;
    end else begin
      if (rd_cnt != 0) begin
        rd_cnt--;
        if (rd_cnt == 0) issue_read(pend_off);
      end
      if (ctrlReq && !mute) begin
        age++;
        if (age == 2) begin
          age = 0;
          ctrlAck = 1'b1;
          if (ctrlWrite) begin
            chk("wr_addr", 32'(ctrlAddr), woff);
            chk("wr_data", ctrlWriteData,
                tb_pat(woff) ^ flip_bit(woff));
            mem[woff] = ctrlWriteData;
            woff = (woff + 1) % NW;
          end else begin
            chk("rd_addr", 32'(ctrlAddr), roff);
            if (fast) issue_read(roff);
            else begin
              pend_off = roff;
              rd_cnt = 4;
            end
            roff = (roff + 1) % NW;
          end
        end
      end else begin
        age = 0;
      end
    end
  end

  // monitor
  initial forever begin
    @(negedge memoryClock);
    if (readDataValid === 1'b1) begin
      rdv_cnt++;
      if (!first_seen) begin
        first_rd = readReg;
        first_seen = 1;
      end
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rdv_unexpected: readReg %h, want no pulse",
                 readReg);
      end else begin
        chk("readReg", readReg, sb.pop_front());
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 32'(ctrlReq), 0);
    chk({tag, "_wr"}, 32'(ctrlWrite), 0);
    chk({tag, "_addr"}, 32'(ctrlAddr), 0);
    chk({tag, "_wdata"}, ctrlWriteData, 0);
    chk({tag, "_rdreg"}, readReg, 0);
    chk({tag, "_rdv"}, 32'(readDataValid), 0);
    chk({tag, "_cnt"}, 32'(testStateCounter), 0);
    chk({tag, "_done"}, 32'(testDone), 0);
    chk({tag, "_pass"}, 32'(testPass), 0);
    chk({tag, "_err"}, 32'(errorCount), 0);
    chk({tag, "_tmo"}, 32'(timeoutErr), 0);
  endtask

  task automatic wait_done(input int lim, input string name);
    int n;
    n = 0;
    while (testDone !== 1'b1 && n < lim) begin
      @(negedge memoryClock);
      n++;
    end
    if (testDone !== 1'b1) miss(name);
  endtask

  task automatic wait_cnt(input logic [6:0] prev, input int lim,
                          input string name);
    int n;
    n = 0;
    while (testStateCounter === prev && n < lim) begin
      @(negedge memoryClock);
      n++;
    end
    if (testStateCounter === prev) miss(name);
  endtask

  initial begin
    int base, hi, n;
    repeat (3) @(negedge memoryClock);
    chk_zero("reset");
    resetn = 1'b1;
    @(negedge memoryClock);

`ifdef HRAM_TEST_ERRINJ_EN
    inj_run = 0;
    start = 1'b1;
    @(negedge memoryClock);
    wait_cnt(7'd0, 400, "inj_pass0");
    chk("inj0_cnt", 32'(testStateCounter), 1);
    chk("inj0_pass", 32'(testPass), 1);
    chk("inj0_err", 32'(errorCount), 0);
    inj_run = 1;
    wait_cnt(7'd1, 400, "inj_pass1");
    chk("inj1_cnt", 32'(testStateCounter), 2);
    chk("inj1_err", 32'(errorCount), 1);
    chk("inj1_pass", 32'(testPass), 0);
    repeat (5) @(negedge memoryClock);
    chk("inj1_hold", 32'(testDone), 1);
    chk("inj1_req", 32'(ctrlReq), 0);
    start = 1'b0;
    @(negedge memoryClock);
`else
    // clean single pass
    first_seen = 0;
    start = 1'b1;
    @(negedge memoryClock);
    wait_done(400, "run1_done");
    start = 1'b0;
    @(negedge memoryClock);
    chk("run1_pass", 32'(testPass), 1);
    chk("run1_err", 32'(errorCount), 0);
    chk("run1_cnt", 32'(testStateCounter), 1);
    chk("run1_tmo", 32'(timeoutErr), 0);
    chk("run1_rdv", rdv_cnt, NW);
    chk("run1_first", first_rd, 32'h5A3C_5A3C);

    // ack/valid in IDLE must be ignored
    base = rdv_cnt;
    stray = 1;
    repeat (4) @(negedge memoryClock);
    chk("stray_req", 32'(ctrlReq), 0);
    chk("stray_done", 32'(testDone), 1);
    chk("stray_rdv", rdv_cnt - base, 0);

    // corrupted read of offset 3
    corrupt_off = 3;
    start = 1'b1;
    @(negedge memoryClock);
    wait_done(400, "run2_done");
    repeat (5) @(negedge memoryClock);
    chk("run2_err", 32'(errorCount), 1);
    chk("run2_pass", 32'(testPass), 0);
    chk("run2_hold", 32'(testDone), 1);
    chk("run2_req", 32'(ctrlReq), 0);
    chk("run2_cnt", 32'(testStateCounter), 2);
    start = 1'b0;
    corrupt_off = -1;
    repeat (2) @(negedge memoryClock);

    // read data in the same cycle as ack
    fast = 1;
    base = rdv_cnt;
    start = 1'b1;
    @(negedge memoryClock);
    wait_done(400, "run3_done");
    start = 1'b0;
    @(negedge memoryClock);
    chk("run3_pass", 32'(testPass), 1);
    chk("run3_err", 32'(errorCount), 0);
    chk("run3_cnt", 32'(testStateCounter), 3);
    chk("run3_rdv", rdv_cnt - base, NW);
    fast = 0;

    // controller never acks
    mute = 1;
    start = 1'b1;
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge memoryClock);
      if (ctrlReq) hi++;
    end
    chk("tmo_req_cycles", hi, 15);
    chk("tmo_flag", 32'(timeoutErr), 1);
    chk("tmo_done", 32'(testDone), 1);
    chk("tmo_pass", 32'(testPass), 0);
    chk("tmo_cnt", 32'(testStateCounter), 4);
    start = 1'b0;
    mute = 0;
    repeat (2) @(negedge memoryClock);

    // reset during read phase, then 130 looping passes
    base = rdv_cnt;
    start = 1'b1;
    n = 0;
    while (rdv_cnt - base < 3 && n < 400) begin
      @(negedge memoryClock);
      n++;
    end
    if (rdv_cnt - base < 3) miss("mid_read");
    resetn = 1'b0;
    @(negedge memoryClock);
    resetn = 1'b1;
    sb.delete();
    woff = 0;
    roff = 0;
    chk_zero("midrst");
    base = rdv_cnt;
    for (int p = 0; p < 130; p++) begin
      wait_cnt(7'(p % 128), 300, "loop_pass");
      chk("loop_cnt", 32'(testStateCounter), (p + 1) % 128);
      chk("loop_pass", 32'(testPass), 1);
      if (p == 129) start = 1'b0;
    end
    @(negedge memoryClock);
    chk("loop_rdv", rdv_cnt - base, 130 * NW);
    chk("loop_final_cnt", 32'(testStateCounter), 2);
`endif

    repeat (2) @(negedge memoryClock);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hram_test_sequencer.md
Name: hram_test_sequencer

Overview:
Upstream traffic generator and checker for the HyperRAM controller on the nano4k board. It writes a deterministic 32-bit pattern across a word range, reads the range back and compares each word. It publishes readReg, readDataValid and testStateCounter, which feed the on-chip logic-analyser capture (data and trigger), plus pass/fail status for LEDs.

Parameters:
ADDR_W, 21, word-address width toward the controller (8 MB / 4 B per word).
NUM_WORDS, 256, words exercised per pass; legal range 1..2**ADDR_W.
BASE_ADDR, 0, first word address of each pass.
SEED, 32'hA5C3_5A3C, XOR seed for the data pattern.
TIMEOUT_CYC, 1023, max cycles waiting on ctrlAck or ctrlReadValid.
LOOP, 1, 1 = restart automatically after a passing run; 0 = single run.

Ports:
memoryClock  in  1  sole clock, controller clock domain.
resetn  in  1  synchronous active-low reset.
start  in  1  level; run begins when high in IDLE.
ctrlReq  out  1  request to controller; held until ctrlAck.
ctrlWrite  out  1  1 = write, 0 = read; valid with ctrlReq.
ctrlAddr  out  ADDR_W  word address; valid with ctrlReq.
ctrlWriteData  out  32  write data; valid with ctrlReq & ctrlWrite.
ctrlAck  in  1  one-cycle accept pulse (write complete, or read issued).
ctrlReadValid  in  1  one-cycle pulse; ctrlReadData valid.
ctrlReadData  in  32  read data.
readReg  out  32  last word captured from ctrlReadData.
readDataValid  out  1  one-cycle pulse, aligned with readReg update.
testStateCounter  out  7  completed-pass counter (analyser trigger).
testDone  out  1  run finished (pass or fail).
testPass  out  1  run finished with zero mismatches.
errorCount  out  16  mismatch count, saturating at 16'hFFFF.
timeoutErr  out  1  sticky; a controller handshake timed out.

Behaviour:
- Every register and output resets to 0 on memoryClock edge with resetn=0. Reset mid-transaction drops ctrlReq the same cycle and returns to IDLE.
- pattern(i) = {~i[15:0], i[15:0]} ^ SEED, where i = word offset 0..NUM_WORDS-1. Address = BASE_ADDR + i, truncated to ADDR_W bits (wraps).
- FSM:
  - IDLE -> WR_REQ when start=1. On entry: i, errorCount, timeoutErr, testDone and testPass are cleared.
  - WR_REQ: ctrlReq=1, ctrlWrite=1. ctrlAck -> i+1. If i was NUM_WORDS-1, go to RD_REQ with i=0; otherwise stay in WR_REQ.
  - RD_REQ: ctrlReq=1, ctrlWrite=0. ctrlAck -> RD_WAIT.
  - RD_WAIT: ctrlReadValid -> readReg<=ctrlReadData and readDataValid=1 the next cycle. Compare against pattern(i); a mismatch increments errorCount. Then next read, or DONE after the last word.
  - ctrlReadValid arriving in the same cycle as ctrlAck in RD_REQ is accepted. RD_WAIT is skipped in that case.
  - DONE: testDone=1, testPass=(errorCount==0 && !timeoutErr). testStateCounter increments by 1 on entry, wrapping 127->0.
    - LOOP=1 and pass and start=1: go to IDLE after 1 cycle, which immediately restarts.
    - Otherwise: hold until start=0, then go to IDLE.
- Outputs ctrlReq/ctrlAddr/ctrlWrite/ctrlWriteData are registered and stable while ctrlReq=1.
- The timeout counter restarts on every ctrlReq assertion and on every RD_WAIT entry. Reaching TIMEOUT_CYC sets timeoutErr, drops ctrlReq and goes to DONE with testPass=0.
- ctrlReadValid outside RD_REQ/RD_WAIT is ignored; readDataValid stays 0.
- ctrlAck outside WR_REQ/RD_REQ is ignored.

Optional Feature:
HRAM_TEST_ERRINJ_EN
- Defined: during the write phase of every odd-numbered pass (testStateCounter[0]=1), word offset 5 is written with bit 0 inverted. Requires NUM_WORDS>5. That pass must end with errorCount=1 and testPass=0.
- Undefined: no injection logic is synthesised and patterns are always exact.

Decomposition:
- Package hram_test_pkg: FSM state enum, 32-bit SEED default, pattern function, error-counter width constant.
- One sub-module, hram_pattern_gen: combinational pattern(i) plus registered address/data pipeline. Shared by the write and compare paths.

Test Plan:
- NUM_WORDS=8, ideal controller model (ack 2 cycles, read data 4 cycles later), start=1 -> 8 writes, 8 reads, 8 readDataValid pulses, first readReg=32'h5A3C_5A3C, testPass=1, testStateCounter=1.
- Model corrupts read of offset 3 (XOR 32'h1) -> errorCount=1, testPass=0, FSM holds in DONE until start=0.
- Controller never acks, TIMEOUT_CYC=15 -> ctrlReq high exactly 15 cycles then low, timeoutErr=1, testDone=1, testPass=0.
- LOOP=1 with 130 passing passes -> testStateCounter wraps 127->0->1->2; readDataValid count=130*NUM_WORDS.
- resetn=0 for 1 cycle mid read phase -> next cycle all outputs 0, ctrlReq=0; a new run after start completes with pass.
- HRAM_TEST_ERRINJ_EN defined, LOOP=1 -> pass 0 clean; pass 1 errorCount=1, readReg at offset 5 = pattern(5)^1, run stops.
